// File: rtl/div_32bit.sv
// Iterative signed divider: restoring shift-subtract, one quotient bit per clock.
// Optional macro DIV_REMAINDER_EN adds the data_remainder output.
module div_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] b_abs;
  logic             q_neg;
  logic             exc_flag;
`ifdef DIV_REMAINDER_EN
  logic             a_neg;
`endif

  logic [WIDTH-1:0] a_abs_in;
  logic [WIDTH-1:0] b_abs_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Magnitudes are unsigned, so |0x80000000| stays representable as 0x80000000.
  // The partial remainder is always below |B| <= 2^31, so its top bit is zero and
  // a WIDTH+1 bit trial subtraction is enough to carry the borrow as its sign.
  always_comb begin
    a_abs_in = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    b_abs_in = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, b_abs};
  end

  // A start pulse in any state relatches operands and restarts; a divide by zero
  // skips straight to DONE with the dividend parked in the remainder register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      rem            <= '0;
      quo            <= '0;
      b_abs          <= '0;
      q_neg          <= 1'b0;
      exc_flag       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
      a_neg          <= 1'b0;
      data_remainder <= '0;
`endif
    end else if (ctrl_DIV) begin
      b_abs          <= b_abs_in;
      q_neg          <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      counter        <= '0;
      data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
      a_neg          <= data_operandA[WIDTH-1];
`endif
      if (data_operandB == '0) begin
        state    <= DONE;
        quo      <= '0;
        rem      <= data_operandA;
        exc_flag <= 1'b1;
      end else begin
        state    <= RUN;
        quo      <= a_abs_in;
        rem      <= '0;
        exc_flag <= (data_operandA == MIN_NEG) && (data_operandB == '1);
      end
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: ;
        RUN: begin
          rem     <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo     <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          counter <= counter + 1'b1;
          if (counter == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (q_neg) quo <= ~quo + 1'b1;
`ifdef DIV_REMAINDER_EN
          if (a_neg) rem <= ~rem + 1'b1;
`endif
          state <= DONE;
        end
        DONE: begin
          data_result    <= quo;
          data_exception <= exc_flag;
          data_resultRDY <= 1'b1;
`ifdef DIV_REMAINDER_EN
          data_remainder <= rem;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32bit.sv
// Self-checking bench for div_32bit: a directed vector table plus hand-written
// restart, reset-abort and reset-vs-start sequences.
module tb_div_32bit;

  logic        clock;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  int checks;
  int failures;

  div_32bit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    logic [31:0] rem;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives a one-cycle start pulse; returns at the negedge after start edge E.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV      = 1'b0;
  endtask

  // Counts edges after E until the ready strobe shows, bounded so it cannot hang.
  task automatic waitReady(output int n);
    n = 0;
    while (!data_resultRDY && n < 60) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic runVector(input string tag, input vec_t v);
    int n;
    applyStimulus(v.a, v.b);
    waitReady(n);
    checkOutput({tag, " latency"}, n, v.lat);
    checkOutput({tag, " result"}, data_result, v.res);
    checkOutput({tag, " exception"}, {31'b0, data_exception}, {31'b0, v.exc});
`ifdef DIV_REMAINDER_EN
    checkOutput({tag, " remainder"}, data_remainder, v.rem);
`endif
    @(negedge clock);
    checkOutput({tag, " rdy one cycle"}, {31'b0, data_resultRDY}, 32'd0);
    checkOutput({tag, " result hold"}, data_result, v.res);
  endtask

  initial begin
    int n;
    int rdy_seen;
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    vecs[0]  = '{32'd100,      32'd7,        32'd14,       1'b0, 32'd2,        34};
    vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0, 32'hFFFFFFFE, 34};
    vecs[2]  = '{32'd5,        32'd0,        32'd0,        1'b1, 32'd5,        1};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32'd0,        34};
    vecs[4]  = '{32'h80000000, 32'd2,        32'hC0000000, 1'b0, 32'd0,        34};
    vecs[5]  = '{32'd0,        32'd5,        32'd0,        1'b0, 32'd0,        34};
    vecs[6]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 32'd1,        34};
    vecs[7]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        1'b0, 32'hFFFFFFFF, 34};
    vecs[8]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0, 32'd0,        34};
    vecs[9]  = '{32'd1,        32'h80000000, 32'd0,        1'b0, 32'd1,        34};
    vecs[10] = '{32'hFFFFFFFF, 32'd0,        32'd0,        1'b1, 32'hFFFFFFFF, 1};
    vecs[11] = '{32'h80000000, 32'h80000000, 32'd1,        1'b0, 32'd0,        34};

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("reset result", data_result, 32'd0);
    checkOutput("reset exception", {31'b0, data_exception}, 32'd0);
    checkOutput("reset rdy", {31'b0, data_resultRDY}, 32'd0);
`ifdef DIV_REMAINDER_EN
    checkOutput("reset remainder", data_remainder, 32'd0);
`endif

    for (int i = 0; i < 12; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Restart at E+10 abandons 100/7; only 81/9 may report, 34 edges later.
    applyStimulus(32'd100, 32'd7);
    rdy_seen = 0;
    repeat (9) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    data_operandA = 32'd81;
    data_operandB = 32'd9;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    checkOutput("restart no early rdy", rdy_seen, 32'd0);
    waitReady(n);
    checkOutput("restart latency", n, 32'd34);
    checkOutput("restart result", data_result, 32'd9);
    checkOutput("restart exception", {31'b0, data_exception}, 32'd0);

    // Reset at E+20 aborts silently and clears the outputs.
    applyStimulus(32'd100, 32'd7);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort result cleared", data_result, 32'd0);
    checkOutput("abort exception cleared", {31'b0, data_exception}, 32'd0);
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    checkOutput("abort no rdy", rdy_seen, 32'd0);
    applyStimulus(32'd20, 32'd4);
    waitReady(n);
    checkOutput("post-abort latency", n, 32'd34);
    checkOutput("post-abort result", data_result, 32'd5);

    // Start coincident with reset: reset wins, nothing ever completes.
    @(negedge clock);
    reset         = 1'b1;
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    @(negedge clock);
    reset    = 1'b0;
    ctrl_DIV = 1'b0;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    checkOutput("reset-vs-start no rdy", rdy_seen, 32'd0);
    checkOutput("reset-vs-start result", data_result, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_32bit.md
Name: div_32bit

Overview:
- Iterative signed 32-bit integer divider; the multi-cycle counterpart to the single-cycle bitwise and arithmetic ALU subelements.
- Sits beside the ALU in the execute stage.
- The pipeline stalls on `ctrl_DIV` and resumes on `data_resultRDY`.
- Restoring shift-subtract algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- ctrl_DIV  input  1  start pulse; operands sampled on the same edge
- data_operandA  input  WIDTH  dividend, two's complement
- data_operandB  input  WIDTH  divisor, two's complement
- data_result  output  WIDTH  quotient, truncated toward zero
- data_exception  output  1  divide-by-zero or overflow flag, valid with result
- data_resultRDY  output  1  one-cycle completion strobe

Behaviour:
- Interface: one clock (`clock`); reset (`reset`) is synchronous and active-high.
- Reset values: data_result=0, data_exception=0, data_resultRDY=0, state=IDLE, counter=0.
- Reset mid-operation aborts the divide with no resultRDY pulse.
- States:
  - IDLE
  - RUN: 32 cycles, counter 0..31.
  - FIX: sign correction.
  - DONE: resultRDY=1 for this one cycle, then back to IDLE.
- IDLE→RUN: ctrl_DIV=1 at edge E.
  - Latch |A| and |B|.
  - Latch sign flag = A[31]^B[31] and A[31].
  - Clear the remainder register and the counter.
- RUN, each cycle:
  - Shift {rem,quo} left 1.
  - Trial = rem - |B| (WIDTH+1 bits).
  - If trial ≥ 0: rem=trial, quo[0]=1; else quo[0]=0.
  - Counter increments; at 31 go to FIX.
- FIX: quotient negated if the sign flag is set; remainder negated if A was negative.
- Latency: data_resultRDY high during the cycle following edge E+34, i.e. 34 edges after start.
- data_result and data_exception update with resultRDY and hold until the next start or reset.
- Divisor zero: detected at edge E.
  - Skip RUN and go to DONE.
  - data_result=0, data_exception=1, resultRDY asserted after edge E+1.
- Overflow 0x80000000 / 0xFFFFFFFF: full iteration runs.
  - data_result=0x80000000, data_exception=1.
- |A| of 0x80000000 handled as unsigned 0x80000000 internally (WIDTH+1 datapath); no other overflow cases.
- ctrl_DIV while in RUN/FIX/DONE: current operation abandoned, new operands latched, restart from RUN with full latency; no resultRDY for the abandoned op.
- ctrl_DIV coincident with reset: reset wins, state IDLE.
- Dividend 0: result 0, exception 0, normal latency.

Optional Feature:
- Macro: DIV_REMAINDER_EN.
- Defined:
  - Adds output port data_remainder, WIDTH bits, reset 0.
  - Updated with resultRDY; sign follows the dividend; A = B*result + remainder.
  - On divide-by-zero it equals operand A.
  - On overflow case it equals 0.
- Undefined: port absent and remainder negation logic removed; quotient behaviour identical.

Test Plan:
- reset, then ctrl_DIV with A=100, B=7 → resultRDY 34 edges later; result=14, exception=0; remainder=2 if DIV_REMAINDER_EN.
- A=-100 (0xFFFFFF9C), B=7 → result=0xFFFFFFF2 (-14), exception=0; remainder=0xFFFFFFFE (-2).
- A=5, B=0 → resultRDY 1 edge later; result=0, exception=1; remainder=5.
- A=0x80000000, B=0xFFFFFFFF → result=0x80000000, exception=1; A=0x80000000, B=2 → result=0xC0000000, exception=0.
- Start A=100, B=7; re-pulse ctrl_DIV at edge E+10 with A=81, B=9 → single resultRDY at (E+10)+34; result=9.
- Start A=100, B=7; assert reset at E+20 → resultRDY never pulses; outputs 0; a following fresh divide 20/4 → result 5 with nominal latency.
